// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and default widths for the run controller.
// Watchdog compare logic is enabled by defining RUN_CTRL_WDOG_EN.
package run_ctrl_pkg;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int CW = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/run_wdog.sv
// Run-cycle counter with clear-on-launch, saturation and watchdog limit flag.
// The limit compare exists only when RUN_CTRL_WDOG_EN is defined; otherwise limit_o is 0.
module run_wdog #(
   parameter int          CW      = 16,
   parameter int unsigned MAX_CYC = 32'hFFFF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [CW-1:0] cnt_o,
   output logic          limit_o
);
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

`ifdef RUN_CTRL_WDOG_EN
   // Flags the last permitted RUN cycle so the FSM exits after exactly MAX_CYC cycles.
   assign limit_o = (cnt_q == CW'(MAX_CYC - 1));
`else
   assign limit_o = 1'b0;
`endif
endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset, launches it on go, and arbitrates dat_mem
// between host and core. Watchdog timeout is enabled by defining RUN_CTRL_WDOG_EN.
module run_ctrl #(
   parameter int          AW        = run_ctrl_pkg::AW,
   parameter int          DW        = run_ctrl_pkg::DW,
   parameter int          CW        = run_ctrl_pkg::CW,
   parameter int unsigned MAX_CYC   = 32'hFFFF,
   parameter int unsigned START_CYC = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          go,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic [DW-1:0] host_rdata,
   output logic          host_rvalid,
   output logic          core_start,
   input  logic          core_done,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          finished,
   output logic          timeout,
   output logic [CW-1:0] cycle_cnt
);
   import run_ctrl_pkg::*;

   localparam int SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

   state_t         state_q, state_d;
   logic [SCW-1:0] scnt_q, scnt_d;
   logic           timeout_q, timeout_d;
   logic           rvalid_q, rvalid_d;
   logic [DW-1:0]  rdata_q, rdata_d;
   logic           host_side;
   logic           start_entry;
   logic           start_last;
   logic           wdog_limit;
   logic           wdog_fire;

   assign host_side   = (state_q == S_IDLE) || (state_q == S_DONE);
   assign start_entry = host_side && go;
   assign start_last  = (scnt_q == SCW'(START_CYC - 1));
   assign wdog_fire   = (state_q == S_RUN) && !core_done && wdog_limit;

   run_wdog #(
      .CW      (CW),
      .MAX_CYC (MAX_CYC)
   ) u_wdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (start_entry),
      .inc_i   (state_q == S_RUN),
      .cnt_o   (cycle_cnt),
      .limit_o (wdog_limit)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         scnt_q    <= '0;
         timeout_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         scnt_q    <= scnt_d;
         timeout_q <= timeout_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      scnt_d    = '0;
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE, S_DONE: if (go) state_d = S_START;
         S_START: begin
            scnt_d = scnt_q + SCW'(1);
            if (start_last) state_d = S_RUN;
         end
         S_RUN: if (core_done || wdog_limit) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      if (start_entry) begin
         timeout_d = 1'b0;
      end else if (wdog_fire) begin
         timeout_d = 1'b1;
      end
   end

   // Memory mux is selected by registered state only, so go never reaches mem_* combinationally.
   always_comb begin
      core_start = (state_q != S_RUN);
      busy       = (state_q == S_START) || (state_q == S_RUN);
      finished   = (state_q == S_DONE);
      host_gnt   = host_side && host_req;
      if (state_q == S_RUN) begin
         mem_we    = core_we;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end else begin
         mem_we    = host_gnt && host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
   end

   always_comb begin
      rvalid_d = host_gnt && !host_we;
      rdata_d  = rvalid_d ? mem_rdata : rdata_q;
   end

   assign host_rvalid = rvalid_q;
   assign host_rdata  = rdata_q;
   assign timeout     = timeout_q;
endmodule

// File: tb/tb_run_ctrl.sv
// Randomized bench for run_ctrl: a bench-side dat_mem plus a shadow memory and
// arithmetic run-length predictions serve as the reference.
module tb_run_ctrl;
   localparam int AW   = 8;
   localparam int DW   = 8;
   localparam int CW   = 16;
   localparam int MAXC = 48;
   localparam int SC   = 2;
`ifdef RUN_CTRL_WDOG_EN
   localparam bit WDOG = 1'b1;
`else
   localparam bit WDOG = 1'b0;
`endif

   logic          clk, reset_n, go;
   logic          host_req, host_we, host_gnt, host_rvalid;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata, host_rdata;
   logic          core_start, core_done, core_we;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          busy, finished, timeout;
   logic [CW-1:0] cycle_cnt;

   logic [DW-1:0] env_mem [256];
   logic [DW-1:0] shadow  [256];
   int            wq[$];
   int            total = 0;
   int            bad   = 0;

   run_ctrl #(
      .AW(AW), .DW(DW), .CW(CW), .MAX_CYC(MAXC), .START_CYC(SC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .go(go),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
      .host_rvalid(host_rvalid), .core_start(core_start), .core_done(core_done),
      .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .finished(finished),
      .timeout(timeout), .cycle_cnt(cycle_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) if (mem_we) env_mem[mem_addr] <= mem_wdata;
   assign mem_rdata = env_mem[mem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      go = 1'b0; host_req = 1'b0; host_we = 1'b0;
      core_done = 1'b0; core_we = 1'b0;
   endtask

   task automatic note_write(input logic [7:0] a, input logic [7:0] d);
      shadow[a] = d;
      wq.push_back(int'(a));
   endtask

   task automatic host_write(input logic [7:0] a, input logic [7:0] d);
      host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
      @(negedge clk);
      check("wr_gnt", host_gnt, 1);
      check("wr_mem_we", mem_we, 1);
      check("wr_cstart", core_start, 1);
      tick();
      note_write(a, d);
      quiet();
   endtask

   task automatic host_read(input logic [7:0] a);
      host_req = 1'b1; host_we = 1'b0; host_addr = a;
      @(negedge clk);
      check("rd_gnt", host_gnt, 1);
      check("rd_mem_we", mem_we, 0);
      tick();
      host_req = 1'b0;
      @(negedge clk);
      check("rd_valid", host_rvalid, 1);
      check($sformatf("rd_data@%0h", a), host_rdata, shadow[a]);
      tick();
      @(negedge clk);
      check("rd_drop", host_rvalid, 0);
      check("rd_hold", host_rdata, shadow[a]);
      tick();
   endtask

   task automatic read_some(input int n);
      for (int k = 0; k < n; k++) host_read(8'(wq[$urandom_range(0, wq.size() - 1)]));
   endtask

   // go in IDLE/DONE, optionally with a simultaneous host write, then the START window.
   task automatic launch(input bit with_wr, input logic [7:0] wa, input logic [7:0] wd);
      go = 1'b1; host_req = with_wr; host_we = 1'b1; host_addr = wa; host_wdata = wd;
      @(negedge clk);
      check("go_cstart", core_start, 1);
      check("go_gnt", host_gnt, with_wr);
      tick();
      if (with_wr) note_write(wa, wd);
      go = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 8'($urandom);
      for (int i = 0; i < SC; i++) begin
         @(negedge clk);
         check("st_busy", busy, 1);
         check("st_cstart", core_start, 1);
         check("st_gnt", host_gnt, 0);
         check("st_mem_we", mem_we, 0);
         check("st_cnt", cycle_cnt, 0);
         check("st_timeout", timeout, 0);
         tick();
      end
      quiet();
   endtask

   // kd = RUN cycle (1-based) in which core_done rises, 0 = never.
   task automatic run_core(input int kd, input bit first_store);
      int  exp_len;
      bit  exp_to;
      exp_to  = WDOG && (kd == 0 || kd > MAXC);
      exp_len = exp_to ? MAXC : kd;
      for (int i = 1; i <= exp_len; i++) begin
         core_done  = (i == kd);
         core_we    = 1'($urandom_range(0, 1));
         core_addr  = 8'($urandom);
         core_wdata = 8'($urandom);
         if (first_store && i == 1) begin
            core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'h33;
         end
         host_req  = 1'($urandom_range(0, 1));
         host_we   = 1'($urandom_range(0, 1));
         host_addr = 8'($urandom);
         @(negedge clk);
         check("run_cstart", core_start, 0);
         check("run_gnt", host_gnt, 0);
         check("run_mem_we", mem_we, core_we);
         check("run_mem_addr", mem_addr, core_addr);
         check("run_mem_wdata", mem_wdata, core_wdata);
         check("run_cnt", cycle_cnt, i - 1);
         check("run_fin", finished, 0);
         tick();
         if (core_we) note_write(core_addr, core_wdata);
      end
      quiet();
      @(negedge clk);
      check("end_fin", finished, 1);
      check("end_busy", busy, 0);
      check("end_cstart", core_start, 1);
      check("end_cnt", cycle_cnt, exp_len);
      check("end_timeout", timeout, exp_to);
      tick();
   endtask

   initial begin
      int kd;
      reset_n = 1'b0;
      quiet();
      host_addr = '0; host_wdata = '0; core_addr = '0; core_wdata = '0;
      host_req = 1'b1;
      #12;
      @(negedge clk);
      check("rst_cstart", core_start, 1);
      check("rst_gnt", host_gnt, 1);
      check("rst_rvalid", host_rvalid, 0);
      check("rst_rdata", host_rdata, 0);
      check("rst_busy", busy, 0);
      check("rst_fin", finished, 0);
      check("rst_timeout", timeout, 0);
      check("rst_cnt", cycle_cnt, 0);
      host_req = 1'b0;
      reset_n = 1'b1;
      tick();

      host_write(8'h10, 8'h5A);
      host_read(8'h10);
      for (int k = 0; k < 5; k++) host_write(8'($urandom), 8'($urandom));
      read_some(2);

      launch(1'b0, 8'h00, 8'h00);
      run_core(40, 1'b1);
      host_read(8'h20);

      launch(1'b1, 8'($urandom), 8'($urandom));
      run_core($urandom_range(1, MAXC), 1'b0);
      read_some(2);

      if (WDOG) begin
         launch(1'b0, 8'h00, 8'h00);
         run_core(0, 1'b0);
         launch(1'b0, 8'h00, 8'h00);
         run_core(MAXC, 1'b0);
      end

      for (int r = 0; r < 6; r++) begin
         kd = WDOG ? int'($urandom_range(0, MAXC + 10)) : int'($urandom_range(1, MAXC + 10));
         launch(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
         run_core(kd, 1'b0);
         read_some(3);
      end

      // Asynchronous reset in the middle of a run.
      launch(1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) tick();
      @(negedge clk);
      #1 reset_n = 1'b0;
      host_req = 1'b1; host_we = 1'b0;
      #1;
      check("mrst_cstart", core_start, 1);
      check("mrst_gnt", host_gnt, 1);
      check("mrst_rvalid", host_rvalid, 0);
      check("mrst_rdata", host_rdata, 0);
      check("mrst_busy", busy, 0);
      check("mrst_fin", finished, 0);
      check("mrst_timeout", timeout, 0);
      check("mrst_cnt", cycle_cnt, 0);
      host_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      read_some(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
